// File: rtl/syst_array_mm.sv
// Output-stationary N x N systolic multiplier: streams A columns / B rows in, drains rows of C.
// Define SYST_ARRAY_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module syst_array_mm #(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OW    = 2 * WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:N-1][WIDTH-1:0] a_col,
    input  logic [0:N-1][WIDTH-1:0] b_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:N-1][OW-1:0]    out_row,
    output logic                    out_last
);

    localparam int unsigned CntW = $clog2(2 * N + 1);
    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [RowW-1:0]        row_q, row_d;

    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [0:N-1][OW-1:0]   out_row_q, out_row_d;

    logic                   accept;
    logic                   out_fire;
    logic                   last_fire;

    logic [WIDTH-1:0]       a_feed [N];
    logic [WIDTH-1:0]       b_feed [N];
    logic [WIDTH-1:0]       a_in   [N][N];
    logic [WIDTH-1:0]       b_in   [N][N];
    logic [WIDTH-1:0]       a_op_q [N][N];
    logic [WIDTH-1:0]       b_op_q [N][N];
    logic [OW-1:0]          acc_q  [N][N];

    assign accept    = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign last_fire = out_fire & out_last_q;

    function automatic logic [OW-1:0] ext(input logic [WIDTH-1:0] v);
`ifdef SYST_ARRAY_SIGNED_EN
        return OW'($signed(v));
`else
        return OW'(v);
`endif
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (N == 1) begin
                        state_d = StFlush;
                        cnt_d   = '0;
                    end else begin
                        state_d = StLoad;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (cnt_q == CntW'(N - 1)) begin
                        state_d = StFlush;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StFlush: begin
                // Last operand needs 2N-1 edges to reach the far corner PE.
                if (cnt_q == CntW'(2 * N - 2)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (out_fire) begin
                    if (out_last_q) begin
                        state_d = StIdle;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready_d  = (state_d == StIdle) || (state_d == StLoad);
        out_valid_d = (state_d == StDrain);
        out_last_d  = (state_d == StDrain) && (row_d == RowW'(N - 1));
        out_row_d   = out_row_q;
        if (state_d != StDrain) begin
            out_row_d = '0;
        end else if ((state_q != StDrain) || out_fire) begin
            for (int r = 0; r < N; r++) begin
                if (row_d == RowW'(r)) begin
                    for (int j = 0; j < N; j++) begin
                        out_row_d[j] = acc_q[r][j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;

    // ------------------------------------------------------------------
    // Input skew: row/column i sees its operand i edges later than index 0.
    // Non-accepted cycles inject zeros so gaps and flush add nothing.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_feed[i] = accept ? a_col[i] : '0;
            assign b_feed[i] = accept ? b_row[i] : '0;
        end else begin : g_chain
            logic [WIDTH-1:0] a_sk_q [i];
            logic [WIDTH-1:0] b_sk_q [i];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int d = 0; d < i; d++) begin
                        a_sk_q[d] <= '0;
                        b_sk_q[d] <= '0;
                    end
                end else begin
                    a_sk_q[0] <= accept ? a_col[i] : '0;
                    b_sk_q[0] <= accept ? b_row[i] : '0;
                    for (int d = 1; d < i; d++) begin
                        a_sk_q[d] <= a_sk_q[d-1];
                        b_sk_q[d] <= b_sk_q[d-1];
                    end
                end
            end

            assign a_feed[i] = a_sk_q[i-1];
            assign b_feed[i] = b_sk_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid: a travels right, b travels down, C stays in place.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_feed[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_op_q[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = b_feed[j];
            for (int i = 1; i < N; i++) begin
                b_in[i][j] = b_op_q[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_op_q[i][j] <= '0;
                    b_op_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_op_q[i][j] <= a_in[i][j];
                    b_op_q[i][j] <= b_in[i][j];
                    acc_q[i][j]  <= last_fire ? '0 :
                                    acc_q[i][j] + ext(a_op_q[i][j]) * ext(b_op_q[i][j]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
        !(in_ready && out_valid));

    a_row_hold: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_row)));

    a_last_valid: assert property (@(posedge clk) disable iff (!rstn)
        out_last |-> out_valid);

endmodule

// File: doc/syst_array_mm.md
# syst_array_mm

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for one matrix pair per job. Operands stream in as one column of A and one row of B per beat. Operand skewing is internal, so the producer presents unskewed vectors. Results drain as N rows of C over a valid/ready stream, and the block sits between the operand-fetch buffers and the result writeback stage.

## Interface
- N, 3: array dimension (rows = columns = beats per job); N ≥ 1
- WIDTH, 16: operand width in bits
- OW, 2*WIDTH: accumulator and output element width
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a_col  in  [0:N-1][WIDTH]  beat k: A[i][k] at index i
- b_row  in  [0:N-1][WIDTH]  beat k: B[k][j] at index j
- out_valid  out  1  out_row holds a valid result row
- out_ready  in  1  consumer accepts the row
- out_row  out  [0:N-1][OW]  row r of C: C[r][j] at index j
- out_last  out  1  high with row N-1

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN. Reset enters IDLE.
- Reset values: in_ready=0 during reset, then 1 in IDLE. out_valid=0, out_last=0, out_row=0. All accumulators, skew registers and counters are 0.
- A beat is accepted when in_valid && in_ready. in_ready=1 only in IDLE and LOAD.
- IDLE: on an accepted beat, go to LOAD. The beat counter becomes 1.
- LOAD: each accepted beat increments the counter. Gaps (in_valid=0) inject zero operands and are harmless. When the N-th beat is accepted, go to FLUSH (from IDLE directly if N=1).
- Skew: a_col[i] is delayed i cycles along row i, and b_row[j] is delayed j cycles along column j.
- PE(i,j) performs acc += a·b on operands of beat k at edge accept(k)+i+j+1.
- FLUSH: lasts exactly 2N-1 cycles, then go to DRAIN.
- DRAIN: out_valid=1. out_row=row r (r starts at 0) and stays stable while out_ready=0. On out_valid && out_ready, r increments.
- After the row with out_last=1 is accepted: out_valid falls, all accumulators clear to 0, state returns to IDLE.
- Arithmetic: products are extended to OW bits before accumulating. Accumulation wraps modulo 2^OW with no saturation.
- in_valid is ignored in FLUSH and DRAIN. a_col and b_row are don't-care when not accepted.
- rstn low at any point, including mid-LOAD or mid-DRAIN, aborts the job immediately with reset values. The partial job is discarded.

## Timing
- Cycle 0 is the cycle the first beat is accepted. With back-to-back beats and out_ready=1:
  - out_valid first high in cycle 3N-1
  - rows are presented in cycles 3N-1 … 4N-2
  - in_ready is high again in cycle 4N-1
- Each input gap of g cycles delays all of the above by g.
- Throughput: one job per 4N-1 cycles at best. Jobs are not overlapped.
- All outputs are registered. There are no combinational paths from in_valid or out_ready to any output.

## Configuration
- SYST_ARRAY_SIGNED_EN defined: operands are two's complement and products are sign-extended to OW.
- Not defined: operands are unsigned and zero-extended.
- Either way, all other behaviour is identical.

## Test plan
- N=3, WIDTH=16, unsigned. Beats (a_col; b_row) are [15,4,7];[10,11,12], then [2,5,8];[13,14,15], then [3,6,9];[16,17,18], back-to-back. Required response:
  - cycle 8: row [224,244,264]
  - cycle 9: row [201,216,231]
  - cycle 10: row [318,342,366] with out_last=1
  - in_ready=1 in cycle 11
- Same job with in_valid low for 2 cycles between beats 1 and 2: identical rows, with out_valid first in cycle 10.
- Same job with out_ready low for 3 cycles at row 1: row 1 holds [201,216,231] stable. Rows 0 and 2 are unchanged. in_valid asserted during DRAIN is not accepted.
- Back-to-back second job (A=identity, B=the B above) immediately after the first: rows [10,11,12],[13,14,15],[16,17,18]. This proves the accumulators cleared.
- rstn pulsed low for 1 cycle after 2 beats of job 1:
  - out_valid stays 0 and in_ready returns to 1 after release
  - a fresh full job then produces the correct rows from the first test
- SYST_ARRAY_SIGNED_EN with N=2, A=[[-1,2],[3,-4]], B=[[5,6],[7,-8]] (as 16-bit two's complement): rows [9,-22],[-13,50] as 32-bit signed. Without the macro the same bit patterns give the unsigned products modulo 2^32.
